switch_debounce: RTL

SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

---
 rtl/switch_debounce.sv | 125 ++++++++++++
 1 files changed

// File: rtl/switch_debounce.sv
// -----------------------------------------------------------------------------
// switch_debounce
//
// Debounces WIDTH independent mechanical switch inputs. Each raw level is
// brought into the clk domain through a two-flop synchronizer and then
// qualified by a per-channel stability counter. The debounced level only
// follows the synchronized input once the input has differed from it for
// STABLE_CYCLES consecutive clock edges. Any return to the current debounced
// level restarts the count, so short bounces never reach the output.
//
// Optional edge outputs (rise/fall/changed) are built only when the macro
// SWITCH_DEBOUNCE_EDGE_EN is defined. Without it they are tied to 0 and no
// flops are generated for them. sw_db timing is the same in both builds.
//
// Parameters
//   WIDTH          number of independent switch channels
//   STABLE_CYCLES  consecutive synchronized samples needed before sw_db moves
//                  (legal range 2..65535)
//
// Ports
//   clk      in   single clock, all state changes on its rising edge
//   rst_n    in   asynchronous active-low reset
//   sw       in   [WIDTH]  raw asynchronous (bouncing) switch levels
//   sw_db    out  [WIDTH]  debounced levels, straight from flops
//   rise     out  [WIDTH]  one-cycle pulse when sw_db[i] goes 0->1
//   fall     out  [WIDTH]  one-cycle pulse when sw_db[i] goes 1->0
//   changed  out           one-cycle pulse when any sw_db bit changes
// -----------------------------------------------------------------------------
module switch_debounce #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  // Terminal count: the edge that finds the counter here while the input
  // still differs is the edge that updates sw_db.
  localparam logic [15:0] CNT_MAX = 16'(STABLE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer. Nothing downstream ever looks at sw directly.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] s1_reg;
  logic [WIDTH-1:0] s2_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg <= '0;
      s2_reg <= '0;
    end else begin
      s1_reg <= sw;
      s2_reg <= s1_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel stability counters.
  // update[i] is high for the edge on which channel i's debounced level flips.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] update;
  logic [WIDTH-1:0] sw_db_next;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
      logic [15:0] cnt_reg;
      logic        differ;

      assign differ         = s2_reg[gi] ^ sw_db[gi];
      assign update[gi]     = differ && (cnt_reg == CNT_MAX);
      assign sw_db_next[gi] = update[gi] ? s2_reg[gi] : sw_db[gi];

      // Clear whenever the input agrees with the output (bounce restart) and
      // also on the update edge itself; otherwise count up. The clear at
      // CNT_MAX is what keeps the counter saturated below STABLE_CYCLES.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (!differ || (cnt_reg == CNT_MAX)) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + 16'd1;
        end
      end
    end
  endgenerate

  // Debounced levels held in one register vector so the output is a clean
  // flop bank with no combinational path back to sw.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_db <= '0;
    end else begin
      sw_db <= sw_db_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Edge pulses, registered on the same edge that sw_db moves. A channel can
  // only move in one direction per edge, so rise and fall never overlap.
  // ---------------------------------------------------------------------------
`ifdef SWITCH_DEBOUNCE_EDGE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise    <= '0;
      fall    <= '0;
      changed <= 1'b0;
    end else begin
      rise    <= update & s2_reg;
      fall    <= update & ~s2_reg;
      changed <= |update;
    end
  end
`else
  assign rise    = '0;
  assign fall    = '0;
  assign changed = 1'b0;
`endif

endmodule
